// File: rtl/simd_shader_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : simd_shader_core                                             |
// | Description : Multicycle SIMD vector core. Host loads the instruction      |
// |               memory and register file, pulses start. Each instruction     |
// |               runs FETCH/EXEC/WB with per-lane merge masking and           |
// |               saturating add/sub. Runs until HALT or end of memory.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module simd_shader_core #(
   parameter int LANES      = 4,
   parameter int LANE_W     = 8,
   parameter int NREGS      = 8,
   parameter int PROG_DEPTH = 16,
   localparam int VW = LANES * LANE_W,
   localparam int RA = $clog2(NREGS),
   localparam int PA = $clog2(PROG_DEPTH),
   localparam int IW = 4 + LANES + 3 * RA
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          prog_we,
   input  logic [PA-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic          reg_we,
   input  logic [RA-1:0] reg_waddr,
   input  logic [VW-1:0] reg_wdata,
   input  logic [RA-1:0] reg_raddr,
   output logic [VW-1:0] reg_rdata,
   output logic [PA-1:0] pc,
   output logic [15:0]   instr_count
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_MIN  = 4'd6;
   localparam logic [3:0] OP_MAX  = 4'd7;
   localparam logic [3:0] OP_ADDS = 4'd8;
   localparam logic [3:0] OP_SUBS = 4'd9;
   localparam logic [3:0] OP_MOV  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [PA-1:0] LAST_PC = PA'(PROG_DEPTH - 1);

   // S_END is the wrap-up cycle after the WB of the last memory address
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_END   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        state;
   logic [IW-1:0] imem [PROG_DEPTH];
   logic [VW-1:0] regs [NREGS];
   logic [IW-1:0] ir;
   logic [VW-1:0] result;

   logic [3:0]       op;
   logic [LANES-1:0] mask;
   logic [RA-1:0]    dest;
   logic [RA-1:0]    src_a;
   logic [RA-1:0]    src_b;
   logic             host_ok;
   logic             writes_dest;
   logic [VW-1:0]    va;
   logic [VW-1:0]    vb;
   logic [VW-1:0]    vd;
   logic [VW-1:0]    lane_res;

   assign op          = ir[IW-1 -: 4];
   assign mask        = ir[3*RA +: LANES];
   assign dest        = ir[2*RA +: RA];
   assign src_a       = ir[RA +: RA];
   assign src_b       = ir[0 +: RA];
   assign host_ok     = (state == S_IDLE) || (state == S_DONE);
   assign writes_dest = (dest != '0) && (op <= OP_MOV);
   assign va          = regs[src_a];
   assign vb          = regs[src_b];
   assign vd          = regs[dest];
   // r0 is never written, so it always reads back as zero
   assign reg_rdata   = regs[reg_raddr];

   // Per-lane ALU; masked-off lanes keep the old destination value
   logic [LANE_W-1:0] la;
   logic [LANE_W-1:0] lb;
   logic [LANE_W-1:0] lr;
   logic [LANE_W:0]   lsum;
   always_comb begin
      lane_res = vd;
      la       = '0;
      lb       = '0;
      lr       = '0;
      lsum     = '0;
      for (int l = 0; l < LANES; l++) begin
         la   = va[l*LANE_W +: LANE_W];
         lb   = vb[l*LANE_W +: LANE_W];
         lsum = {1'b0, la} + {1'b0, lb};
         case (op)
            OP_ADD:  lr = lsum[LANE_W-1:0];
            OP_SUB:  lr = la - lb;
            OP_MUL:  lr = la * lb;
            OP_AND:  lr = la & lb;
            OP_OR:   lr = la | lb;
            OP_XOR:  lr = la ^ lb;
            OP_MIN:  lr = (la < lb) ? la : lb;
            OP_MAX:  lr = (la > lb) ? la : lb;
            OP_ADDS: lr = lsum[LANE_W] ? '1 : lsum[LANE_W-1:0];
            OP_SUBS: lr = (la < lb) ? '0 : la - lb;
            OP_MOV:  lr = la;
            default: lr = vd[l*LANE_W +: LANE_W];
         endcase
         if (mask[l]) begin
            lane_res[l*LANE_W +: LANE_W] = lr;
         end
      end
   end

   // Instruction memory: host-written only while the core is not running
   always_ff @(posedge clk) begin
      if (prog_we && host_ok) begin
         imem[prog_addr] <= prog_data;
      end
   end

   // Control FSM, register file and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pc          <= '0;
         instr_count <= '0;
         ir          <= '0;
         result      <= '0;
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         if (reg_we && host_ok && (reg_waddr != '0)) begin
            regs[reg_waddr] <= reg_wdata;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_FETCH;
                  busy        <= 1'b1;
                  pc          <= '0;
                  instr_count <= '0;
               end
            end
            S_FETCH: begin
               ir    <= imem[pc];
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (op == OP_HALT) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  result <= lane_res;
                  state  <= S_WB;
               end
            end
            S_WB: begin
               if (writes_dest) begin
                  regs[dest] <= result;
               end
               if (instr_count != 16'hFFFF) begin
                  instr_count <= instr_count + 16'd1;
               end
               if (pc == LAST_PC) begin
                  state <= S_END;
               end else begin
                  pc    <= pc + PA'(1);
                  state <= S_FETCH;
               end
            end
            S_END: begin
               state <= S_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_simd_shader_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_simd_shader_core                                          |
// | Description : Self-checking bench for simd_shader_core (4 lanes x 8 bits). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_simd_shader_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [16:0] prog_data = '0;
   logic        reg_we = 1'b0;
   logic [2:0]  reg_waddr = '0;
   logic [31:0] reg_wdata = '0;
   logic [2:0]  reg_raddr = '0;
   logic [31:0] reg_rdata;
   logic [3:0]  pc;
   logic [15:0] instr_count;

   int passed = 0;
   int total  = 0;

   simd_shader_core dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .pc(pc), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  mask;
      logic [2:0]  dest;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] dpre;
      logic [31:0] exp;
   } vec_t;

   vec_t tab[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [16:0] enc(input logic [3:0] op, input logic [3:0] mask,
                                       input logic [2:0] d, input logic [2:0] a,
                                       input logic [2:0] b);
      return {op, mask, d, a, b};
   endfunction

   // Reference: lane-wise unsigned arithmetic on plain integers
   function automatic logic [31:0] model_op(input int op, input logic [3:0] mask,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] old);
      logic [31:0] r;
      r = old;
      for (int l = 0; l < 4; l++) begin
         int x, y, v;
         x = int'((a >> (8*l)) & 32'hFF);
         y = int'((b >> (8*l)) & 32'hFF);
         case (op)
            0:  v = (x + y) % 256;
            1:  v = (x - y + 256) % 256;
            2:  v = (x * y) % 256;
            3:  v = x & y;
            4:  v = x | y;
            5:  v = x ^ y;
            6:  v = (x < y) ? x : y;
            7:  v = (x > y) ? x : y;
            8:  v = (x + y > 255) ? 255 : x + y;
            9:  v = (x < y) ? 0 : x - y;
            10: v = x;
            default: v = int'((old >> (8*l)) & 32'hFF);
         endcase
         if (mask[l]) r[8*l +: 8] = v[7:0];
      end
      return r;
   endfunction

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk); reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
      @(negedge clk); reg_we = 1'b0;
   endtask

   task automatic wr_prog(input logic [3:0] a, input logic [16:0] d);
      @(negedge clk); prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk); prog_we = 1'b0;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      reg_raddr = a; #1; d = reg_rdata;
   endtask

   // Pulse start (optionally with a same-edge host register write), count edges to done
   task automatic run_prog(input bit wr, input logic [2:0] wa, input logic [31:0] wd,
                           output int cycles);
      @(negedge clk);
      start = 1'b1;
      if (wr) begin reg_we = 1'b1; reg_waddr = wa; reg_wdata = wd; end
      @(posedge clk); #1;
      start = 1'b0; reg_we = 1'b0;
      check("busy_after_start", busy, 1);
      cycles = 0;
      while (done !== 1'b1 && cycles < 200) begin
         @(posedge clk); #1; cycles++;
      end
      if (done !== 1'b1) begin
         check("done_timeout", done, 1);
      end else begin
         check("busy_at_done", busy, 0);
         @(posedge clk); #1;
         check("done_one_cycle", done, 0);
      end
   endtask

   initial begin
      int          cyc;
      logic [31:0] rd;
      logic [31:0] m [8];
      int          nfix;

      // Directed rows with hand-derived results
      tab[0]  = '{4'd0,  4'hF, 3'd3, 32'h01020304, 32'h05060708, 32'h00000000, 32'h06080A0C};
      tab[1]  = '{4'd8,  4'hF, 3'd3, 32'hF0F0F0F0, 32'h20202020, 32'h00000000, 32'hFFFFFFFF};
      tab[2]  = '{4'd0,  4'hF, 3'd3, 32'hF0F0F0F0, 32'h20202020, 32'h00000000, 32'h10101010};
      tab[3]  = '{4'd9,  4'hF, 3'd3, 32'h20202020, 32'hF0F0F0F0, 32'h55555555, 32'h00000000};
      tab[4]  = '{4'd0,  4'h5, 3'd3, 32'h01020304, 32'h05060708, 32'hAAAAAAAA, 32'hAA08AA0C};
      tab[5]  = '{4'd0,  4'hF, 3'd0, 32'h01020304, 32'h05060708, 32'h00000000, 32'h00000000};
      tab[6]  = '{4'd2,  4'hF, 3'd3, 32'h05060708, 32'h05060708, 32'h00000000, 32'h19243140};
      tab[7]  = '{4'd6,  4'hF, 3'd3, 32'h01020304, 32'h05060708, 32'h00000000, 32'h01020304};
      tab[8]  = '{4'd7,  4'hF, 3'd3, 32'h01020304, 32'h05060708, 32'h00000000, 32'h05060708};
      tab[9]  = '{4'd1,  4'hF, 3'd3, 32'h01020304, 32'h05060708, 32'h00000000, 32'hFCFCFCFC};
      tab[10] = '{4'd5,  4'hF, 3'd3, 32'h01020304, 32'h05060708, 32'h00000000, 32'h0404040C};
      tab[11] = '{4'd12, 4'hF, 3'd3, 32'h01020304, 32'h05060708, 32'h12345678, 32'h12345678};
      tab[12] = '{4'd10, 4'h8, 3'd3, 32'h01020304, 32'h05060708, 32'hAAAAAAAA, 32'h01AAAAAA};
      nfix = 13;
      // Random rows, expectations from the reference model
      for (int i = nfix; i < 18; i++) begin
         tab[i].op   = 4'($urandom_range(0, 14));
         tab[i].mask = 4'($urandom);
         tab[i].dest = 3'd3;
         tab[i].va   = $urandom;
         tab[i].vb   = $urandom;
         tab[i].dpre = $urandom;
         tab[i].exp  = model_op(int'(tab[i].op), tab[i].mask, tab[i].va, tab[i].vb, tab[i].dpre);
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pc", pc, 0);
      check("rst_count", instr_count, 0);
      rd_reg(3'd5, rd);
      check("rst_reg5", rd, 0);
      @(negedge clk); rst_n = 1'b1;

      // Single-instruction table
      for (int i = 0; i < 18; i++) begin
         wr_reg(3'd1, tab[i].va);
         wr_reg(3'd2, tab[i].vb);
         wr_reg(3'd3, tab[i].dpre);
         wr_prog(4'd0, enc(tab[i].op, tab[i].mask, tab[i].dest, 3'd1, 3'd2));
         wr_prog(4'd1, enc(4'd15, 4'd0, 3'd0, 3'd0, 3'd0));
         run_prog(1'b0, 3'd0, 32'd0, cyc);
         check($sformatf("row%0d_cycles", i), cyc, 5);
         check($sformatf("row%0d_count", i), instr_count, 1);
         rd_reg(tab[i].dest, rd);
         check($sformatf("row%0d_result", i), rd, tab[i].exp);
      end

      // Host write on the same edge as start is seen by the first instruction
      wr_reg(3'd1, 32'h01020304);
      wr_prog(4'd0, enc(4'd0, 4'hF, 3'd3, 3'd1, 3'd2));
      wr_prog(4'd1, enc(4'd15, 4'd0, 3'd0, 3'd0, 3'd0));
      run_prog(1'b1, 3'd2, 32'h10101010, cyc);
      rd_reg(3'd3, rd);
      check("same_edge_write", rd, 32'h11121314);

      // Random multi-instruction programs against the model
      for (int t = 0; t < 5; t++) begin
         int n;
         n = $urandom_range(1, 8);
         m[0] = '0;
         wr_reg(3'd0, 32'hDEADBEEF);
         for (int r = 1; r < 8; r++) begin
            m[r] = $urandom;
            wr_reg(3'(r), m[r]);
         end
         for (int k = 0; k < n; k++) begin
            logic [3:0] op, mk;
            logic [2:0] d, a, b;
            op = 4'($urandom_range(0, 14));
            mk = 4'($urandom);
            d = 3'($urandom); a = 3'($urandom); b = 3'($urandom);
            wr_prog(4'(k), enc(op, mk, d, a, b));
            if (d != 0 && op <= 10) m[d] = model_op(int'(op), mk, m[a], m[b], m[d]);
         end
         wr_prog(4'(n), enc(4'd15, 4'd0, 3'd0, 3'd0, 3'd0));
         run_prog(1'b0, 3'd0, 32'd0, cyc);
         check($sformatf("rnd%0d_cycles", t), cyc, 3*n + 2);
         check($sformatf("rnd%0d_count", t), instr_count, 64'(n));
         for (int r = 0; r < 8; r++) begin
            rd_reg(3'(r), rd);
            check($sformatf("rnd%0d_r%0d", t, r), rd, m[r]);
         end
      end

      // start / prog_we / reg_we while busy are ignored
      wr_reg(3'd1, 32'h01020304);
      wr_reg(3'd2, 32'h05060708);
      wr_prog(4'd0, enc(4'd0, 4'hF, 3'd3, 3'd1, 3'd2));
      for (int k = 1; k < 5; k++) wr_prog(4'(k), enc(4'd11, 4'hF, 3'd3, 3'd1, 3'd2));
      wr_prog(4'd5, enc(4'd15, 4'd0, 3'd0, 3'd0, 3'd0));
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1; cyc++;
         if (cyc == 3) begin
            start = 1'b1;
            prog_we = 1'b1; prog_addr = 4'd5; prog_data = enc(4'd11, 4'hF, 3'd1, 3'd0, 3'd0);
            reg_we = 1'b1; reg_waddr = 3'd1; reg_wdata = 32'hFFFFFFFF;
         end else if (cyc == 4) begin
            start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
         end
      end
      check("busy_ign_cycles", cyc, 17);
      check("busy_ign_count", instr_count, 5);
      check("busy_ign_pc", pc, 5);
      rd_reg(3'd1, rd);
      check("busy_ign_r1", rd, 32'h01020304);
      rd_reg(3'd3, rd);
      check("busy_ign_r3", rd, 32'h06080A0C);
      repeat (2) @(posedge clk);
      run_prog(1'b0, 3'd0, 32'd0, cyc);
      check("busy_ign_imem", cyc, 17);

      // No HALT: memory full of NOPs runs to the end
      for (int k = 0; k < 16; k++) wr_prog(4'(k), enc(4'd11, 4'hF, 3'd1, 3'd1, 3'd1));
      run_prog(1'b0, 3'd0, 32'd0, cyc);
      check("nohalt_cycles", cyc, 49);
      check("nohalt_count", instr_count, 16);
      check("nohalt_pc", pc, 15);
      rd_reg(3'd1, rd);
      check("nohalt_r1", rd, 32'h01020304);

      // Reset during EXEC aborts the run
      wr_prog(4'd0, enc(4'd0, 4'hF, 3'd3, 3'd1, 3'd2));
      wr_prog(4'd1, enc(4'd15, 4'd0, 3'd0, 3'd0, 3'd0));
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      check("rstrun_busy", busy, 0);
      check("rstrun_done", done, 0);
      rd_reg(3'd1, rd);
      check("rstrun_r1", rd, 0);
      @(negedge clk); rst_n = 1'b1;
      begin
         bit saw;
         saw = 1'b0;
         for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
         end
         check("rstrun_no_done", saw, 0);
      end
      check("rstrun_count", instr_count, 0);
      rd_reg(3'd3, rd);
      check("rstrun_r3", rd, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
